// File: rtl/pc_seq_unit_pkg.sv
//------------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the PC / exception sequencer:
//   - pc_src_e : next-PC source select encodings driven by the controller
//   - default reset, interrupt/illegal-op and exception vectors
//------------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic [2:0] {
      PCS_SEQ   = 3'd0,
      PCS_BR    = 3'd1,
      PCS_J     = 3'd2,
      PCS_JR    = 3'd3,
      PCS_ILLOP = 3'd4,
      PCS_XADR  = 3'd5   // 6 and 7 also select the exception vector
   } pc_src_e;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h8000_0000;
   localparam logic [31:0] PC_ILLOP_VEC_DEF = 32'h8000_0004;
   localparam logic [31:0] PC_XADR_VEC_DEF  = 32'h8000_0008;

endpackage

// File: rtl/pc_seq_unit_if.sv
//------------------------------------------------------------------------------
// pc_seq_unit_if
// Bundles the controller/fetch-side signals of pc_seq_unit.
//   master : controller view (drives selects/targets/fetch_ready/irq_in)
//   slave  : pc_seq_unit view (drives pc, pc_plus_4, irq_take, epc,
//            advance, instret)
//------------------------------------------------------------------------------
interface pc_seq_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [2:0]        pc_src;
   logic              br_cond;
   logic [15:0]       imm16;
   logic [25:0]       jt;
   logic [ADDR_W-1:0] jr_target;
   logic              fetch_ready;
   logic              irq_in;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus_4;
   logic              irq_take;
   logic [ADDR_W-1:0] epc;
   logic              advance;
   logic [31:0]       instret;

   modport master (
      output pc_src, br_cond, imm16, jt, jr_target, fetch_ready, irq_in,
      input  pc, pc_plus_4, irq_take, epc, advance, instret
   );

   modport slave (
      input  pc_src, br_cond, imm16, jt, jr_target, fetch_ready, irq_in,
      output pc, pc_plus_4, irq_take, epc, advance, instret
   );
endinterface

// File: rtl/pc_seq_unit_irq_latch.sv
//------------------------------------------------------------------------------
// pc_irq_latch
// Rising-edge detector plus sticky pending flag for the peripheral interrupt.
// Only instantiated when PC_IRQ_EN is defined.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   irq_i   in  interrupt level
//   take_i  in  interrupt accepted this cycle (clears pending)
//   pend_o  out interrupt pending
//------------------------------------------------------------------------------
module pc_irq_latch (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_i,
   input  logic take_i,
   output logic pend_o
);
   logic irq_q;
   logic pend_q, pend_d;

   // A new edge arriving in the same cycle as a take must not be lost.
   always_comb begin
      pend_d = pend_q;
      if (irq_i && !irq_q) begin
         pend_d = 1'b1;
      end else if (take_i) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         irq_q  <= irq_i;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;
endmodule

// File: rtl/pc_seq_unit.sv
//------------------------------------------------------------------------------
// pc_seq_unit
// Program counter and exception sequencer: PC register, next-PC selection,
// interrupt capture with kernel-mode masking, EPC, fetch wait states and a
// retired-instruction counter.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of pc_seq_unit_if (pc_src, br_cond, imm16, jt,
//          jr_target, fetch_ready, irq_in in; pc, pc_plus_4, irq_take, epc,
//          advance, instret out)
// Build option: PC_IRQ_EN enables interrupt capture; when undefined irq_in is
// ignored and irq_take is tied low.
//------------------------------------------------------------------------------
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [31:0] RESET_VEC = PC_RESET_VEC_DEF,
   parameter logic [31:0] ILLOP_VEC = PC_ILLOP_VEC_DEF,
   parameter logic [31:0] XADR_VEC  = PC_XADR_VEC_DEF
) (
   input  logic          clk,
   input  logic          reset,
   pc_seq_unit_if.slave  bus
);
   localparam int unsigned MSB = ADDR_W - 1;
   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] ILL_PC = ADDR_W'(ILLOP_VEC);
   localparam logic [ADDR_W-1:0] XAD_PC = ADDR_W'(XADR_VEC);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [31:0]       instret_q, instret_d;

   logic              sup;
   logic              advance;
   logic              irq_take;
   logic [ADDR_W-1:0] pc_plus_4;
   logic [MSB-1:0]    br_off;
   logic [MSB-1:0]    br_low;
   logic [ADDR_W-1:0] j_tgt;

   assign sup     = pc_q[MSB];
   assign advance = bus.fetch_ready;

   // All PC arithmetic stays below the supervisor bit so carries cannot flip it.
   assign pc_plus_4 = {sup, pc_q[MSB-1:0] + (MSB)'(4)};
   assign br_off    = {{(ADDR_W-19){bus.imm16[15]}}, bus.imm16, 2'b00};
   assign br_low    = pc_plus_4[MSB-1:0] + br_off;

`ifdef PC_IRQ_EN
   logic irq_pend;

   pc_irq_latch u_irq (
      .clk    (clk),
      .rst_n  (reset),
      .irq_i  (bus.irq_in),
      .take_i (irq_take),
      .pend_o (irq_pend)
   );

   // Kernel mode masks the interrupt; it stays pending until user mode.
   assign irq_take = advance & irq_pend & ~sup;
`else
   logic unused_irq_in;
   assign unused_irq_in = bus.irq_in;
   assign irq_take      = 1'b0;
`endif

   always_comb begin
      j_tgt        = '0;
      j_tgt[27:0]  = {bus.jt, 2'b00};
      j_tgt[MSB]   = sup;
   end

   always_comb begin
      pc_d      = pc_q;
      epc_d     = epc_q;
      instret_d = instret_q;
      if (advance) begin
         if (irq_take) begin
            // Interrupted instruction re-executes after return.
            pc_d  = ILL_PC;
            epc_d = pc_q;
         end else begin
            instret_d = instret_q + 32'd1;
            case (bus.pc_src)
               PCS_SEQ: pc_d = pc_plus_4;
               PCS_BR:  pc_d = bus.br_cond ? {sup, br_low} : pc_plus_4;
               PCS_J:   pc_d = j_tgt;
               // User code cannot raise its privilege through jr.
               PCS_JR:  pc_d = {sup & bus.jr_target[MSB], bus.jr_target[MSB-1:0]};
               PCS_ILLOP: begin
                  pc_d  = ILL_PC;
                  epc_d = pc_plus_4;
               end
               default: begin
                  pc_d  = XAD_PC;
                  epc_d = pc_plus_4;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RST_PC;
         epc_q     <= '0;
         instret_q <= '0;
      end else begin
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         instret_q <= instret_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus_4 = pc_plus_4;
   assign bus.irq_take  = irq_take;
   assign bus.epc       = epc_q;
   assign bus.advance   = advance;
   assign bus.instret   = instret_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
//------------------------------------------------------------------------------
// tb_pc_seq_unit
// Scoreboard bench for pc_seq_unit: a driver applies one cycle of stimulus,
// derives the expected outputs for that cycle from a behavioural model and
// queues them; a monitor pops and compares on every falling edge.
//------------------------------------------------------------------------------
module tb_pc_seq_unit;
   import pc_pkg::*;

   localparam logic [31:0] RV = 32'h8000_0000;
   localparam logic [31:0] IV = 32'h8000_0004;
   localparam logic [31:0] XV = 32'h8000_0008;
   localparam logic [31:0] K  = 32'h8000_0000;
   localparam logic [31:0] U  = 32'h7FFF_FFFF;
`ifdef PC_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_seq_unit_if #(.ADDR_W(32)) bus ();

   pc_seq_unit #(
      .ADDR_W    (32),
      .RESET_VEC (RV),
      .ILLOP_VEC (IV),
      .XADR_VEC  (XV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pp4;
      logic [31:0] epc;
      logic [31:0] instret;
      logic        adv;
      logic        take;
   } exp_t;

   exp_t sbq[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Architectural state of the reference model.
   logic [31:0] m_pc   = RV;
   logic [31:0] m_epc  = '0;
   logic [31:0] m_ir   = '0;
   logic        m_prev = 1'b0;
   logic        m_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic step(input logic rst_l, input logic [2:0] src, input logic br,
                       input logic [15:0] imm, input logic [25:0] jtf,
                       input logic [31:0] jr, input logic fr, input logic irq);
      exp_t        e;
      logic        take;
      logic        npend;
      logic [31:0] pp4;
      logic [31:0] off;
      @(posedge clk);
      #1;
      reset           = rst_l;
      bus.pc_src      = src;
      bus.br_cond     = br;
      bus.imm16       = imm;
      bus.jt          = jtf;
      bus.jr_target   = jr;
      bus.fetch_ready = fr;
      bus.irq_in      = irq;
      if (!rst_l) begin
         m_pc = RV; m_epc = '0; m_ir = '0; m_prev = 1'b0; m_pend = 1'b0;
      end
      pp4  = (m_pc & K) | ((m_pc + 32'd4) & U);
      take = IRQ_EN && fr && m_pend && !m_pc[31];
      e.pc = m_pc; e.pp4 = pp4; e.epc = m_epc; e.instret = m_ir;
      e.adv = fr; e.take = take;
      sbq.push_back(e);
      if (rst_l) begin
         if (IRQ_EN) begin
            npend  = (irq && !m_prev) ? 1'b1 : (take ? 1'b0 : m_pend);
            m_prev = irq;
            m_pend = npend;
         end
         if (fr) begin
            if (take) begin
               m_epc = m_pc;
               m_pc  = IV;
            end else begin
               m_ir = m_ir + 32'd1;
               off  = 32'(int'($signed(imm)) * 4);
               case (src)
                  3'd0: m_pc = pp4;
                  3'd1: m_pc = br ? ((m_pc & K) | ((pp4 + off) & U)) : pp4;
                  3'd2: m_pc = (m_pc & K) | (32'(jtf) * 32'd4);
                  3'd3: m_pc = (m_pc & jr & K) | (jr & U);
                  3'd4: begin m_epc = pp4; m_pc = IV; end
                  default: begin m_epc = pp4; m_pc = XV; end
               endcase
            end
         end
      end
   endtask

   task automatic seq(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic jr_to(input logic [31:0] t);
      step(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, t, 1'b1, 1'b0);
   endtask

   // Monitor: one queued expectation per clock cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pc",        bus.pc,               e.pc);
            chk("pc_plus_4", bus.pc_plus_4,        e.pp4);
            chk("epc",       bus.epc,              e.epc);
            chk("instret",   bus.instret,          e.instret);
            chk("advance",   32'(bus.advance),     32'(e.adv));
            chk("irq_take",  32'(bus.irq_take),    32'(e.take));
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.pc_src = '0; bus.br_cond = 1'b0; bus.imm16 = '0; bus.jt = '0;
      bus.jr_target = '0; bus.fetch_ready = 1'b0; bus.irq_in = 1'b0;
      #1 reset = 1'b0;

      // Reset, then sequential fetch from the reset vector.
      step(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      seq(4);

      // Branch taken / not taken from user pc 0x100.
      jr_to(32'h0000_0100);
      step(1'b1, 3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b1, 1'b0);
      jr_to(32'h0000_0100);
      step(1'b1, 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b1, 1'b0);

      // jr privilege masking, user then kernel.
      jr_to(32'h0000_0040);
      jr_to(32'h8000_1000);
      step(1'b1, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      jr_to(32'h8000_0040);
      jr_to(32'h8000_1000);
      step(1'b1, 3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);

      // User-mode interrupt at pc 0x200.
      jr_to(32'h0000_0200);
      step(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
      seq(3);

      // Kernel-mode interrupt stays pending until jr to user code.
      step(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
      seq(3);
      jr_to(32'h0000_0300);
      seq(3);

      // Fetch stall with a pending jump.
      for (int unsigned i = 0; i < 4; i++)
         step(1'b1, 3'd2, 1'b0, 16'h0, 26'h123_4567, 32'h0, 1'b0, 1'b0);
      step(1'b1, 3'd2, 1'b0, 16'h0, 26'h123_4567, 32'h0, 1'b1, 1'b0);
      seq(2);

      // Reset in the middle of a stall.
      step(1'b1, 3'd2, 1'b0, 16'h0, 26'h3F_0000, 32'h0, 1'b0, 1'b1);
      step(1'b0, 3'd2, 1'b0, 16'h0, 26'h3F_0000, 32'h0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      seq(2);

      // Randomized traffic.
      for (int unsigned i = 0; i < 400; i++) begin
         step(1'b1,
              3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)),
              16'($urandom),
              26'($urandom),
              ($urandom_range(0, 1) != 0) ? (32'($urandom) & U) : 32'($urandom),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0);
      end

      // Bounded drain of the scoreboard.
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (sbq.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", sbq.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
